// File: rtl/mac_pkg.sv
// Shared types, defaults and arithmetic helpers for the MAC array.
package mac_pkg;

  localparam int NUM_FILT_DEF = 40;
  localparam int NUM_LANE_DEF = 36;
  localparam int DW_DEF       = 8;
  localparam int WW_DEF       = 8;
  localparam int ACC_W_DEF    = 32;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } ctl_t;

  function automatic int prod_w(input int dw, input int ww);
    return dw + ww;
  endfunction

  function automatic int tree_w(input int dw, input int ww,
                                input int lanes);
    return dw + ww + $clog2(lanes);
  endfunction

  // Operands arrive pre-extended to 64 bits; returns {saturated, value}.
  function automatic logic [64:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int w,
                                          input bit sgn);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic [63:0] r;
    logic sat;
    s = $signed(a) + $signed(b);
    if (sgn) begin
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
    end else begin
      hi = (64'sd1 <<< w) - 64'sd1;
      lo = '0;
    end
    r = s;
    sat = 1'b0;
    if (s > hi) begin
      r = hi;
      sat = 1'b1;
    end else if (s < lo) begin
      r = lo;
      sat = 1'b1;
    end
    return {sat, r};
  endfunction

endpackage

// File: rtl/mac_array_acc_if.sv
// Beat input / packed result bundle between fetch logic, MAC array and requant.
interface mac_array_acc_if
  import mac_pkg::*;
#(
  parameter int NUM_FILT = NUM_FILT_DEF,
  parameter int NUM_LANE = NUM_LANE_DEF,
  parameter int DW       = DW_DEF,
  parameter int WW       = WW_DEF,
  parameter int ACC_W    = ACC_W_DEF
) ();

  logic                         din_vld;
  logic                         first;
  logic                         last;
  logic [DW*NUM_LANE-1:0]       din;
  logic [WW*NUM_LANE*NUM_FILT-1:0] weight;
  logic [ACC_W*NUM_FILT-1:0]    sum;
  logic                         sum_vld;
  logic [NUM_FILT-1:0]          ovf;

  modport master (
    output din_vld, first, last, din, weight,
    input  sum, sum_vld, ovf
  );

  modport slave (
    input  din_vld, first, last, din, weight,
    output sum, sum_vld, ovf
  );

endinterface

// File: rtl/mac_dot_acc.sv
// One filter: lane multipliers (S1), registered adder tree (S2),
// saturating accumulator with sticky overflow and result hold (S3).
module mac_dot_acc
  import mac_pkg::*;
#(
  parameter int NUM_LANE = NUM_LANE_DEF,
  parameter int DW       = DW_DEF,
  parameter int WW       = WW_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter bit SIGNED   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  input  logic                   s1_vld,
  input  ctl_t                   s2,
  input  logic [DW*NUM_LANE-1:0] din,
  input  logic [WW*NUM_LANE-1:0] w,
  output logic [ACC_W-1:0]       sum,
  output logic                   ovf
);

  localparam int PW = prod_w(DW, WW);
  localparam int TW = tree_w(DW, WW, NUM_LANE);

  logic [PW-1:0]    prod_d [NUM_LANE];
  logic [PW-1:0]    prod_q [NUM_LANE];
  logic [TW-1:0]    tree_d, tree_q;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [ACC_W-1:0] sum_d, sum_q;
  logic             ovfa_d, ovfa_q;
  logic             ovf_d, ovf_q;
  logic [63:0]      tree_x, acc_x;
  logic [64:0]      add_r;

  always_comb begin
    for (int k = 0; k < NUM_LANE; k++) begin
      if (SIGNED)
        prod_d[k] = PW'($signed(din[DW*k +: DW]))
                  * PW'($signed(w[WW*k +: WW]));
      else
        prod_d[k] = PW'(din[DW*k +: DW]) * PW'(w[WW*k +: WW]);
    end
  end

  always_comb begin
    tree_d = '0;
    for (int k = 0; k < NUM_LANE; k++) begin
      if (SIGNED)
        tree_d = tree_d + TW'($signed(prod_q[k]));
      else
        tree_d = tree_d + TW'(prod_q[k]);
    end
  end

  always_comb begin
    if (SIGNED) begin
      tree_x = 64'($signed(tree_q));
      acc_x  = 64'($signed(acc_q));
    end else begin
      tree_x = 64'(tree_q);
      acc_x  = 64'(acc_q);
    end
    add_r  = sat_add(acc_x, tree_x, ACC_W, SIGNED);
    acc_d  = acc_q;
    ovfa_d = ovfa_q;
    sum_d  = sum_q;
    ovf_d  = ovf_q;
    if (s2.vld) begin
      if (s2.first) begin
        acc_d  = tree_x[ACC_W-1:0];
        ovfa_d = 1'b0;
      end else begin
        acc_d  = add_r[ACC_W-1:0];
        ovfa_d = ovfa_q | add_r[64];
      end
      if (s2.last) begin
        sum_d = acc_d;
        ovf_d = ovfa_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LANE; k++)
        prod_q[k] <= '0;
      tree_q <= '0;
      acc_q  <= '0;
      ovfa_q <= 1'b0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (in_vld)
        for (int k = 0; k < NUM_LANE; k++)
          prod_q[k] <= prod_d[k];
      if (s1_vld)
        tree_q <= tree_d;
      acc_q  <= acc_d;
      ovfa_q <= ovfa_d;
      sum_q  <= sum_d;
      ovf_q  <= ovf_d;
    end
  end

  assign sum = sum_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/mac_array_acc.sv
// NUM_FILT x NUM_LANE MAC array: shared framing pipeline, per-filter
// dot/accumulate engines, packed result with one shared strobe.
module mac_array_acc
  import mac_pkg::*;
#(
  parameter int NUM_FILT = NUM_FILT_DEF,
  parameter int NUM_LANE = NUM_LANE_DEF,
  parameter int DW       = DW_DEF,
  parameter int WW       = WW_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter bit SIGNED   = 1'b1
) (
  input logic           clk,
  input logic           rst,
  mac_array_acc_if.slave bus
);

  ctl_t s1_d, s1_q;
  ctl_t s2_d, s2_q;
  logic sum_vld_d, sum_vld_q;

  logic [ACC_W-1:0] sum_w [NUM_FILT];
  logic             ovf_w [NUM_FILT];

  // first/last are qualified here so downstream only looks at vld.
  always_comb begin
    s1_d.vld   = bus.din_vld;
    s1_d.first = bus.din_vld & bus.first;
    s1_d.last  = bus.din_vld & bus.last;
    s2_d       = s1_q;
    sum_vld_d  = s2_q.vld & s2_q.last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      sum_vld_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      sum_vld_q <= sum_vld_d;
    end
  end

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
    mac_dot_acc #(
      .NUM_LANE (NUM_LANE),
      .DW       (DW),
      .WW       (WW),
      .ACC_W    (ACC_W),
      .SIGNED   (SIGNED)
    ) u_dot (
      .clk    (clk),
      .rst    (rst),
      .in_vld (bus.din_vld),
      .s1_vld (s1_q.vld),
      .s2     (s2_q),
      .din    (bus.din),
      .w      (bus.weight[WW*NUM_LANE*f +: WW*NUM_LANE]),
      .sum    (sum_w[f]),
      .ovf    (ovf_w[f])
    );
  end

  always_comb begin
    bus.sum = '0;
    bus.ovf = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      bus.sum[ACC_W*f +: ACC_W] = sum_w[f];
      bus.ovf[f] = ovf_w[f];
    end
    bus.sum_vld = sum_vld_q;
  end

endmodule

// File: tb/tb_mac_array_acc.sv
// Bench for mac_array_acc: vector table + scoreboard on the default build,
// hand sequences on a 24-bit-accumulator build and a 3x5 build.
module tb_mac_array_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_array_acc_if b0 ();
  mac_array_acc_if #(.NUM_FILT(4), .ACC_W(24)) b1 ();
  mac_array_acc_if #(.NUM_FILT(3), .NUM_LANE(5)) b2 ();

  mac_array_acc u0 (.clk(clk), .rst(rst), .bus(b0));
  mac_array_acc #(.NUM_FILT(4), .ACC_W(24)) u1 (
    .clk(clk), .rst(rst), .bus(b1));
  mac_array_acc #(.NUM_FILT(3), .NUM_LANE(5)) u2 (
    .clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic [7:0] d;
    logic [7:0] w;
    bit         wf;
    bit         first;
    bit         last;
    int         gap;
    longint     exp;
  } vec_t;

  typedef struct {
    logic [40*32-1:0] sum;
    int               due;
    int               id;
  } exp_t;

  localparam int NV = 15;
  vec_t tv [NV];
  exp_t sb [$];
  exp_t me;
  exp_t pe;

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && b0.sum_vld) begin
      if (sb.size() == 0) begin
        chk("unexpected_sum_vld", 1, 0);
      end else begin
        int fi;
        me = sb.pop_front();
        fi = 0;
        for (int f = 0; f < 40; f++)
          if (b0.sum[32*f +: 32] !== me.sum[32*f +: 32]) begin
            fi = f;
            break;
          end
        chk($sformatf("lat_v%0d", me.id), cyc, me.due);
        chk($sformatf("sum_v%0d_f%0d", me.id, fi),
            longint'($signed(b0.sum[32*fi +: 32])),
            longint'($signed(me.sum[32*fi +: 32])));
        chk($sformatf("ovf_v%0d", me.id), longint'(b0.ovf), 0);
      end
    end
  end

  task automatic beat0(input logic [7:0] d, input logic [7:0] w,
                       input bit wf, input bit fr, input bit la);
    @(negedge clk);
    b0.din_vld = 1'b1;
    b0.first = fr;
    b0.last = la;
    for (int k = 0; k < 36; k++) b0.din[8*k +: 8] = d;
    for (int f = 0; f < 40; f++)
      for (int k = 0; k < 36; k++)
        b0.weight[8*(f*36+k) +: 8] = wf ? 8'(f + 1) : w;
  endtask

  // Idle beats carry junk that must not reach the products.
  task automatic idle0();
    @(negedge clk);
    b0.din_vld = 1'b0;
    b0.first = 1'b1;
    b0.last = 1'b1;
    for (int k = 0; k < 36; k++) b0.din[8*k +: 8] = 8'($urandom);
  endtask

  task automatic beat1(input logic [7:0] d, input bit fr, input bit la);
    @(negedge clk);
    b1.din_vld = 1'b1;
    b1.first = fr;
    b1.last = la;
    for (int k = 0; k < 36; k++) b1.din[8*k +: 8] = d;
    for (int k = 0; k < 36*4; k++) b1.weight[8*k +: 8] = d;
  endtask

  task automatic wait1(output bit ok);
    @(negedge clk);
    b1.din_vld = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (b1.sum_vld) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait2(output bit ok);
    @(negedge clk);
    b2.din_vld = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (b2.sum_vld) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tv[0]  = '{8'd1,   8'd1,   0, 1, 1, 0, 36};
    tv[1]  = '{8'h80,  8'h80,  0, 1, 0, 0, 0};
    tv[2]  = '{8'h80,  8'h80,  0, 0, 0, 0, 0};
    tv[3]  = '{8'h80,  8'h80,  0, 0, 0, 0, 0};
    tv[4]  = '{8'h80,  8'h80,  0, 0, 1, 0, 2359296};
    tv[5]  = '{8'd2,   8'd0,   1, 1, 0, 1, 0};
    tv[6]  = '{8'd2,   8'd0,   1, 0, 0, 1, 0};
    tv[7]  = '{8'd2,   8'd0,   1, 0, 1, 0, 216};
    tv[8]  = '{8'd1,   8'd1,   0, 1, 0, 0, 0};
    tv[9]  = '{8'd1,   8'd1,   0, 0, 0, 0, 0};
    tv[10] = '{8'd3,   8'd1,   0, 1, 1, 0, 108};
    tv[11] = '{8'd1,   8'd1,   0, 0, 1, 0, 144};
    tv[12] = '{8'd1,   8'd1,   0, 0, 1, 0, 180};
    tv[13] = '{8'hFF,  8'd1,   0, 1, 1, 0, -36};
    tv[14] = '{8'd5,   8'hFD,  0, 1, 1, 0, -540};

    b0.din_vld = 0; b0.first = 0; b0.last = 0;
    b0.din = '0; b0.weight = '0;
    b1.din_vld = 0; b1.first = 0; b1.last = 0;
    b1.din = '0; b1.weight = '0;
    b2.din_vld = 0; b2.first = 0; b2.last = 0;
    b2.din = '0; b2.weight = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sum_vld", longint'(b0.sum_vld), 0);
    chk("rst_sum", longint'(|b0.sum), 0);
    chk("rst_ovf", longint'(|b0.ovf), 0);

    for (int i = 0; i < NV; i++) begin
      beat0(tv[i].d, tv[i].w, tv[i].wf, tv[i].first, tv[i].last);
      if (tv[i].last) begin
        pe.due = cyc + 3;
        pe.id = i;
        for (int f = 0; f < 40; f++)
          pe.sum[32*f +: 32] = 32'(tv[i].wf ? tv[i].exp * (f + 1)
                                            : tv[i].exp);
        sb.push_back(pe);
      end
      for (int g = 0; g < tv[i].gap; g++) idle0();
    end
    repeat (6) idle0();
    chk("sb_drained", sb.size(), 0);

    // Reset one cycle after a last: pulse must never appear.
    beat0(8'd1, 8'd1, 0, 1, 1);
    @(negedge clk);
    b0.din_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) idle0();
    chk("rst_mid_sum", longint'(|b0.sum), 0);
    chk("rst_mid_vld", longint'(b0.sum_vld), 0);

    for (int i = 0; i < 20; i++) beat1(8'd127, i == 0, i == 19);
    wait1(ok);
    chk("sat_vld", ok, 1);
    for (int f = 0; f < 4; f++)
      chk($sformatf("sat_sum_f%0d", f),
          longint'($signed(b1.sum[24*f +: 24])), 8388607);
    chk("sat_ovf", longint'(b1.ovf), 15);
    beat1(8'd127, 1, 1);
    wait1(ok);
    chk("clr_vld", ok, 1);
    chk("clr_sum", longint'($signed(b1.sum[0 +: 24])), 580644);
    chk("clr_ovf", longint'(b1.ovf), 0);

    @(negedge clk);
    b2.din_vld = 1'b1;
    b2.first = 1'b1;
    b2.last = 1'b1;
    for (int k = 0; k < 5; k++) b2.din[8*k +: 8] = 8'd1;
    for (int k = 0; k < 15; k++) b2.weight[8*k +: 8] = 8'd1;
    wait2(ok);
    chk("small_vld", ok, 1);
    for (int f = 0; f < 3; f++)
      chk($sformatf("small_sum_f%0d", f),
          longint'($signed(b2.sum[32*f +: 32])), 5);
    chk("small_ovf", longint'(b2.ovf), 0);

    repeat (3) @(negedge clk);
    chk("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
